// File: rtl/alu_op_sequencer_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU instruction sequencer:
//   - ALU opcode constants understood by the datapath ALU
//   - sequencer state encoding (also exported on the debug port)
//   - opcode classification helpers (unary / wide-result / legal)
//   - a small integer max helper used for counter sizing
package alu_seq_pkg;

    // ALU opcodes
    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_AND  = 2;
    localparam int unsigned OP_OR   = 3;
    localparam int unsigned OP_SHR  = 4;
    localparam int unsigned OP_SHRA = 5;
    localparam int unsigned OP_SHL  = 6;
    localparam int unsigned OP_ROR  = 7;
    localparam int unsigned OP_ROL  = 8;
    localparam int unsigned OP_MUL  = 9;
    localparam int unsigned OP_DIV  = 10;
    localparam int unsigned OP_NEG  = 11;
    localparam int unsigned OP_NOT  = 12;

    // Highest opcode the ALU implements; everything above is rejected.
    localparam int unsigned OP_LAST = OP_NOT;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_LOAD_Y = 3'd1,
        S_ALU    = 3'd2,
        S_ZLO    = 3'd3,
        S_ZHI    = 3'd4,
        S_DONE   = 3'd5
    } seq_state_e;

    // Unary ops take their single operand straight off the bus in the ALU
    // cycle, so Y is never loaded for them.
    function automatic bit is_unary(input int unsigned op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    // Wide ops produce a 2-word result that goes to LO/HI instead of Rc.
    function automatic bit is_wide(input int unsigned op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic bit is_legal(input int unsigned op);
        return op <= OP_LAST;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_reg_select_decoder.sv
// reg_select_decoder
//   Binary register index to one-hot register strobe vector.
//   Ports:
//     en      in   1         gate; all outputs low when 0
//     idx     in   IDX_W     register index
//     onehot  out  NUM_REGS  one-hot strobe (all zero for idx >= NUM_REGS)
module reg_select_decoder #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                en,
    input  logic [IDX_W-1:0]    idx,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Steps the register-transfer datapath through one instruction
//   Rz = Ra op Rb, emitting register, Y/Z/HI/LO strobes and the ALU opcode
//   as a Moore machine (every output is a decode of registered state).
//
//   Request handshake: a request is accepted on a rising Clock edge where
//   the sequencer is IDLE (busy=0) and start=1; op/ra/rb/rc are captured at
//   that edge and ignored afterwards. start is ignored whenever busy=1,
//   including the DONE cycle. Completion is a single-cycle done pulse with
//   err qualifying it. There is no queuing.
//
//   Ports:
//     Clock                      in   rising-edge clock
//     clear                      in   asynchronous active-low reset
//     start                      in   request, sampled only in IDLE
//     op                         in   ALU opcode (alu_seq_pkg constants)
//     ra, rb, rc                 in   source A, source B, destination index
//     reg_out                    out  one-hot register-to-bus enable
//     reg_in                     out  one-hot bus-to-register load
//     yin                        out  load Y from bus
//     zhighin, zlowin            out  load Z from ALU result
//     zhighout, zlowout          out  drive Z halves onto bus
//     hiin, loin                 out  load HI / LO from bus
//     alu_op                     out  opcode presented to the ALU
//     busy                       out  high in every state except IDLE
//     done                       out  one-cycle completion pulse
//     err                        out  request was rejected (valid with done)
//     state_dbg                  out  current sequencer state
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OP_W     = 5,
    parameter int MUL_LAT  = 1,
    parameter int DIV_LAT  = 1,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                start,
    input  logic [OP_W-1:0]     op,
    input  logic [IDX_W-1:0]    ra,
    input  logic [IDX_W-1:0]    rb,
    input  logic [IDX_W-1:0]    rc,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic                yin,
    output logic                zhighin,
    output logic                zlowin,
    output logic                zhighout,
    output logic                zlowout,
    output logic                hiin,
    output logic                loin,
    output logic [OP_W-1:0]     alu_op,
    output logic                busy,
    output logic                done,
    output logic                err,
    output seq_state_e          state_dbg
);

    localparam int MAX_LAT = max_int(MUL_LAT, DIV_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    // The opcode must fit on the datapath word; register file and latency
    // bounds are structural limits of the sequencer.
    if ((OP_W > DATA_W) || (OP_W > 32) || (NUM_REGS < 2) || (NUM_REGS > 32) ||
        (MUL_LAT < 1) || (DIV_LAT < 1)) begin : g_param_check
        $error("alu_op_sequencer: illegal parameter combination");
    end

    seq_state_e         state;
    seq_state_e         state_next;

    logic [OP_W-1:0]    op_q;
    logic [IDX_W-1:0]   ra_q;
    logic [IDX_W-1:0]   rb_q;
    logic [IDX_W-1:0]   rc_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt;

    // Request classification, evaluated on the live inputs in IDLE.
    logic               req_unary;
    logic               req_wide;
    logic               req_bad;

    // Classification of the latched instruction.
    logic               cur_unary;
    logic               cur_wide;

    logic               out_en;
    logic [IDX_W-1:0]   out_idx;
    logic               in_en;
    logic [IDX_W-1:0]   in_idx;

    function automatic logic idx_bad(input logic [IDX_W-1:0] idx);
        return 32'(idx) >= 32'(NUM_REGS);
    endfunction

    // ALU hold time minus one; the counter runs down to zero and the final
    // ALU cycle is the one with cnt == 0.
    function automatic logic [CNT_W-1:0] lat_m1(input int unsigned o);
        if (o == OP_MUL) begin
            return CNT_W'(MUL_LAT - 1);
        end else if (o == OP_DIV) begin
            return CNT_W'(DIV_LAT - 1);
        end else begin
            return '0;
        end
    endfunction

    assign req_unary = is_unary(32'(op));
    assign req_wide  = is_wide(32'(op));
    // Only indices the instruction actually uses can make it illegal:
    // unary ops ignore rb, wide ops ignore rc.
    assign req_bad   = !is_legal(32'(op)) || idx_bad(ra) ||
                       (!req_unary && idx_bad(rb)) ||
                       (!req_wide  && idx_bad(rc));

    assign cur_unary = is_unary(32'(op_q));
    assign cur_wide  = is_wide(32'(op_q));

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // Instruction latch and ALU hold counter
    // ---------------------------------------------------------------
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
            err_q <= 1'b0;
            cnt   <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                op_q  <= op;
                ra_q  <= ra;
                rb_q  <= rb;
                rc_q  <= rc;
                err_q <= req_bad;
            end

            // Load on ALU entry. Unary ops enter straight from IDLE, where
            // the opcode is still only on the input pins.
            if ((state_next == S_ALU) && (state != S_ALU)) begin
                cnt <= lat_m1((state == S_IDLE) ? 32'(op) : 32'(op_q));
            end else if ((state == S_ALU) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (req_bad) begin
                        state_next = S_DONE;
                    end else if (req_unary) begin
                        state_next = S_ALU;
                    end else begin
                        state_next = S_LOAD_Y;
                    end
                end
            end
            S_LOAD_Y: state_next = S_ALU;
            S_ALU: begin
                if (cnt == '0) begin
                    state_next = S_ZLO;
                end
            end
            S_ZLO:   state_next = cur_wide ? S_ZHI : S_DONE;
            S_ZHI:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Output decode (Moore)
    // ---------------------------------------------------------------
    always_comb begin
        out_en   = 1'b0;
        out_idx  = ra_q;
        in_en    = 1'b0;
        in_idx   = rc_q;
        yin      = 1'b0;
        zhighin  = 1'b0;
        zlowin   = 1'b0;
        zhighout = 1'b0;
        zlowout  = 1'b0;
        hiin     = 1'b0;
        loin     = 1'b0;
        alu_op   = '0;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_LOAD_Y: begin
                out_en = 1'b1;
                yin    = 1'b1;
            end
            S_ALU: begin
                out_en  = 1'b1;
                out_idx = cur_unary ? ra_q : rb_q;
                alu_op  = op_q;
                // Z captures only once the multi-cycle result has settled.
                if (cnt == '0) begin
                    zlowin  = 1'b1;
                    zhighin = 1'b1;
                end
            end
            S_ZLO: begin
                zlowout = 1'b1;
                if (cur_wide) begin
                    loin = 1'b1;
                end else begin
                    in_en = 1'b1;
                end
            end
            S_ZHI: begin
                zhighout = 1'b1;
                hiin     = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

    reg_select_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_out_dec (
        .en     (out_en),
        .idx    (out_idx),
        .onehot (reg_out)
    );

    reg_select_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_in_dec (
        .en     (in_en),
        .idx    (in_idx),
        .onehot (reg_in)
    );

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Synthesizable control sequencer that drives the register-transfer datapath through one ALU instruction of the form Rz = Ra op Rb, replacing hand-stepped control timing. It sits beside `data_path`, receives a decoded operation plus register indices, and emits one-hot register strobes, Y/Z/HI/LO strobes and the ALU opcode cycle by cycle. It is parametrised in data width, register count and multi-cycle ALU latency, and adds unary, wide-result (HI/LO) and error handling.

## Interface
- DATA_W, 32, datapath word width; passed through for `op` width checks only
- NUM_REGS, 16, number of general registers; any value 2..32
- OP_W, 5, ALU opcode width
- MUL_LAT, 1, cycles the ALU state is held for MUL (≥1)
- DIV_LAT, 1, cycles the ALU state is held for DIV (≥1)
- IDX_W, $clog2(NUM_REGS), derived register-index width
- Clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  OP_W  ALU opcode (constants in package)
- ra, rb, rc  in  IDX_W each  source A, source B, destination
- reg_out  out  NUM_REGS  one-hot register-to-bus enable
- reg_in  out  NUM_REGS  one-hot bus-to-register load
- yin, zhighin, zlowin, zhighout, zlowout, hiin, loin  out  1 each  datapath strobes
- alu_op  out  OP_W  opcode presented to ALU
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; request rejected

## Operation
- Start captured at rising edge in IDLE: op, ra, rb, rc latched; inputs ignored afterwards until IDLE.
- States: IDLE, LOAD_Y, ALU, ZLO, ZHI, DONE. All outputs decoded from registered state (Moore); strobes high for whole cycle.
- LOAD_Y: reg_out[ra]=1, yin=1. Skipped for unary ops (NEG, NOT).
- ALU: alu_op=latched op; reg_out[rb] (binary) or reg_out[ra] (unary). Held LAT cycles (MUL_LAT, DIV_LAT, else 1) via down-counter; zlowin=zhighin=1 only in final ALU cycle.
- ZLO: zlowout=1; narrow op → reg_in[rc]=1; wide op (MUL, DIV) → loin=1.
- ZHI: wide ops only; zhighout=1, hiin=1. rc unused for wide ops.
- DONE: done=1, one cycle, then IDLE.
- alu_op=0 outside ALU state.
- Error: op not in package list, or any used index ≥ NUM_REGS → IDLE→DONE directly, err=1, no strobes ever asserted.
- At most one bit of reg_out and of reg_in high in any cycle; never both the same index.

## Timing
- Reset (clear=0): state IDLE, counter 0, latched fields 0; every output 0 immediately, independent of Clock.
- Reset mid-operation: abandon instruction, no further strobes, no done.
- Latency start-edge → done cycle: binary narrow 4 cycles (LOAD_Y, ALU, ZLO, DONE); unary 3; MUL 4+MUL_LAT; DIV 4+DIV_LAT; error 1.
- start while busy: ignored, no queuing. start in DONE cycle: ignored; earliest accept is the following IDLE cycle.
- Back-to-back: new start may be high on the first IDLE cycle after DONE.
- ra==rb legal; rc==ra legal (write happens in ZLO after reads).

## Structure
- Package alu_seq_pkg: opcode constants (ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHRA=5, SHL=6, ROR=7, ROL=8, MUL=9, DIV=10, NEG=11, NOT=12), state encoding, functions is_unary, is_wide, is_legal.
- Sub-module reg_select_decoder (IDX_W→NUM_REGS one-hot with enable), instantiated twice for reg_out and reg_in.
- Latency counter in the sequencer, width $clog2(max(MUL_LAT,DIV_LAT))+1.

## Test plan
- ADD, ra=2, rb=3, rc=1 (R2=12, R3=5 in datapath) → LOAD_Y/ALU/ZLO strobes on consecutive cycles, R1=17, done 4 cycles after start, err=0.
- MUL with MUL_LAT=3, ra=4, rb=5 → ALU held 3 cycles, zin only on last, loin then hiin, done at cycle 7, no reg_in pulse.
- NEG, ra=6, rc=7 → no yin, reg_out[6] in ALU, reg_in[7] in ZLO, done at cycle 3.
- NUM_REGS=12, rb=13 (or op=31) → done+err next cycle, all strobes 0 throughout.
- start re-asserted during ALU and during DONE → ignored; second start one cycle after DONE accepted.
- clear low during ALU → all outputs 0 same cycle, no done; normal ADD completes after release.
